// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding, legal
// width bound and the carry-majority helper used by the full-adder cell.
package serial_adder_pkg;

    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned WIDTH_MIN = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; the serial adder reuses one instance for every bit.
module serial_adder_full_adder
    import serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    always_comb begin
        sum_o  = a_i ^ b_i ^ cin_i;
        cout_o = maj3(a_i, b_i, cin_i);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop processes
// WIDTH bits LSB first, with a start/done handshake and signed-overflow flag.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gen_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               fa_sum;
    logic               fa_cout;

    serial_adder_full_adder u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    // Subtraction is A + ~B + 1, so the carry flop seeds the +1.
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    res_d   = '0;
                    cmsb_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_MSB) begin
                    cmsb_d = fa_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    // Outputs only move here, so they hold the old result during RUN.
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = cmsb_q ^ fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        Ready = (state_q == StIdle);
        Busy  = (state_q == StRun);
        Done  = (state_q == StDone);
        Sum   = sum_q;
        Cout  = cout_q;
        Ovf   = ovf_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 2 and 32 with a result scoreboard.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a_bus = '0;
    logic [63:0] b_bus = '0;
    logic        sub_r = 1'b0;
    logic        cin_r = 1'b0;
    logic        start8 = 1'b0, start2 = 1'b0, start32 = 1'b0;

    logic        ready8, busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        ready2, busy2, done2, cout2, ovf2;
    logic [1:0]  sum2;
    logic        ready32, busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        ready;
        logic        busy;
        logic        done;
        logic        cout;
        logic        ovf;
        logic [63:0] sum;
    } obs_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .Start(start8), .Sub(sub_r), .A(a_bus[7:0]), .B(b_bus[7:0]),
        .Cin(cin_r), .Ready(ready8), .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8),
        .Ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .Start(start2), .Sub(sub_r), .A(a_bus[1:0]), .B(b_bus[1:0]),
        .Cin(cin_r), .Ready(ready2), .Busy(busy2), .Done(done2), .Sum(sum2), .Cout(cout2),
        .Ovf(ovf2)
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .Start(start32), .Sub(sub_r), .A(a_bus[31:0]),
        .B(b_bus[31:0]), .Cin(cin_r), .Ready(ready32), .Busy(busy32), .Done(done32),
        .Sum(sum32), .Cout(cout32), .Ovf(ovf32)
    );

    function automatic obs_t obs(input int w);
        obs_t o;
        case (w)
            2:       o = '{ready2, busy2, done2, cout2, ovf2, 64'(sum2)};
            32:      o = '{ready32, busy32, done32, cout32, ovf32, 64'(sum32)};
            default: o = '{ready8, busy8, done8, cout8, ovf8, 64'(sum8)};
        endcase
        return o;
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       start2 = v;
            32:      start32 = v;
            default: start8 = v;
        endcase
    endtask

    // Reference: plain integer arithmetic, signed overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic sub, input logic cin);
        exp_t        m;
        logic [63:0] mask, a, b;
        logic [64:0] full;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sub) begin
            m.sum  = (a - b) & mask;
            m.cout = (a >= b);
            m.ovf  = (a[w-1] != b[w-1]) && (m.sum[w-1] != a[w-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            m.sum  = full[63:0] & mask;
            m.cout = full[w];
            m.ovf  = (a[w-1] == b[w-1]) && (m.sum[w-1] != a[w-1]);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic check_result(input string tag, input int w);
        obs_t o;
        exp_t e;
        o = obs(w);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, o.sum, e.sum);
            chk({tag, "_cout"}, 64'(o.cout), 64'(e.cout));
            chk({tag, "_ovf"}, 64'(o.ovf), 64'(e.ovf));
        end
    endtask

    // One full transaction: checks output hold during RUN, latency, result and re-arm.
    task automatic run_op(input string tag, input int w, input logic [63:0] a,
                          input logic [63:0] b, input logic sub, input logic cin);
        obs_t        o;
        logic [63:0] prev;
        int          lat;
        prev  = obs(w).sum;
        a_bus = a;
        b_bus = b;
        sub_r = sub;
        cin_r = cin;
        set_start(w, 1'b1);
        sb.push_back(model(w, a, b, sub, cin));
        tick();
        set_start(w, 1'b0);
        lat = 0;
        while (!obs(w).done && lat < 100) begin
            o = obs(w);
            chk({tag, "_hold"}, o.sum, prev);
            chk({tag, "_busy_run"}, 64'(o.busy), 64'd1);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(w));
        o = obs(w);
        chk({tag, "_busy_done"}, 64'(o.busy), 64'd0);
        chk({tag, "_ready_done"}, 64'(o.ready), 64'd0);
        check_result(tag, w);
        tick();
        o = obs(w);
        chk({tag, "_ready_after"}, 64'(o.ready), 64'd1);
        chk({tag, "_done_after"}, 64'(o.done), 64'd0);
    endtask

    initial begin
        obs_t o;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        o = obs(8);
        chk("rst_ready", 64'(o.ready), 64'd1);
        chk("rst_busy", 64'(o.busy), 64'd0);
        chk("rst_done", 64'(o.done), 64'd0);
        chk("rst_sum", o.sum, 64'd0);
        chk("rst_cout", 64'(o.cout), 64'd0);
        chk("rst_ovf", 64'(o.ovf), 64'd0);
        chk("rst_ready2", 64'(obs(2).ready), 64'd1);
        chk("rst_ready32", 64'(obs(32).ready), 64'd1);

        // Basic add / subtract cases
        run_op("add_5a_3c", 8, 64'h5A, 64'h3C, 1'b0, 1'b0);
        chk("add_5a_3c_const", obs(8).sum, 64'h96);
        run_op("add_ff_01_c", 8, 64'hFF, 64'h01, 1'b0, 1'b1);
        run_op("sub_10_20", 8, 64'h10, 64'h20, 1'b1, 1'b1);
        chk("sub_10_20_const", obs(8).sum, 64'hF0);
        run_op("sub_80_01", 8, 64'h80, 64'h01, 1'b1, 1'b0);

        // Start pulses during RUN and DONE must be ignored
        a_bus = 64'h01;
        b_bus = 64'h01;
        sub_r = 1'b0;
        cin_r = 1'b0;
        start8 = 1'b1;
        sb.push_back(model(8, 64'h01, 64'h01, 1'b0, 1'b0));
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a_bus = 64'hFF;
        b_bus = 64'hFF;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (5) tick();
        chk("ign_done_c9", 64'(obs(8).done), 64'd1);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        o = obs(8);
        chk("ign_ready_c10", 64'(o.ready), 64'd1);
        chk("ign_busy_c10", 64'(o.busy), 64'd0);
        check_result("ign", 8);
        tick();
        chk("ign_not_started", 64'(obs(8).busy), 64'd0);

        // Reset in the middle of an operation
        a_bus = 64'h5A;
        b_bus = 64'h3C;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = obs(8);
        chk("mid_rst_sum", o.sum, 64'd0);
        chk("mid_rst_cout", 64'(o.cout), 64'd0);
        chk("mid_rst_ovf", 64'(o.ovf), 64'd0);
        chk("mid_rst_done", 64'(o.done), 64'd0);
        chk("mid_rst_busy", 64'(o.busy), 64'd0);
        chk("mid_rst_ready", 64'(o.ready), 64'd1);
        run_op("after_rst", 8, 64'h03, 64'h04, 1'b0, 1'b0);

        // Start held high with operands changing every cycle
        start8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a_bus = {32'd0, $urandom};
            b_bus = {32'd0, $urandom};
            sub_r = 1'($urandom_range(0, 1));
            cin_r = 1'($urandom_range(0, 1));
            if (i % 10 == 0) sb.push_back(model(8, a_bus, b_bus, sub_r, cin_r));
            tick();
            o = obs(8);
            chk("held_done", 64'(o.done), 64'((i % 10) == 8));
            chk("held_ready", 64'(o.ready), 64'((i % 10) == 9));
            if (o.done) check_result("held", 8);
        end
        start8 = 1'b0;
        tick();

        // Other widths
        run_op("w2_add", 2, 64'h3, 64'h1, 1'b0, 1'b1);
        run_op("w2_sub", 2, 64'h1, 64'h2, 1'b1, 1'b0);
        run_op("w32_add_ovf", 32, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("w32_sub", 32, {32'd0, $urandom}, {32'd0, $urandom}, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor. Adds or subtracts two WIDTH-bit operands, one bit per clock, LSB first, reusing one full-adder cell and a carry flip-flop.
- Next generation of the team's combinational full-adder work: start/done handshake, operand capture, subtract mode and signed-overflow flag.
- Intended as a low-area arithmetic unit for datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- Start  in  1  request; accepted only when Ready=1
- Sub  in  1  0 = A+B+Cin; 1 = A-B (two's complement); captured with Start
- A  in  WIDTH  operand A, captured with Start
- B  in  WIDTH  operand B, captured with Start
- Cin  in  1  carry-in for add mode; captured with Start; ignored when Sub=1
- Ready  out  1  high in IDLE only
- Busy  out  1  high while bits are being processed
- Done  out  1  one-cycle pulse; result valid
- Sum  out  WIDTH  result, held until the next accepted Start
- Cout  out  1  carry-out; in Sub mode 1 = no borrow (A>=B unsigned)
- Ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE, shift registers, carry FF, bit counter, Sum, Cout and Ovf all cleared to 0. Done=0, Busy=0. Ready=1 from the cycle after reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Ready=1. If Start=1 at an edge, capture A, B, Sub and Cin, then go to RUN.
    - Operand B is stored as ~B when Sub=1.
    - Carry FF is loaded with Cin, or with 1 when Sub=1.
    - Bit counter is cleared.
  - RUN: Busy=1, Ready=0. At each edge:
    - Sum bit = a0^b0^c is shifted into the result register MSB-side; operand registers shift right.
    - Carry FF takes the majority of (a0, b0, c).
    - At counter = WIDTH-2, the current carry is latched as carry-into-MSB for Ovf.
    - After WIDTH bits (counter = WIDTH-1 at the edge), go to DONE.
  - DONE: Done=1 and Busy=0 for exactly one cycle. Sum, Cout and Ovf are valid and stable. Ready=0; Start is ignored. Next state is IDLE.
- Latency: Start sampled at edge of cycle 0; RUN occupies cycles 1..WIDTH; Done=1 in cycle WIDTH+1; Ready=1 again in cycle WIDTH+2.
  - Maximum throughput: one operation per WIDTH+2 cycles.
- Output hold: Sum, Cout and Ovf change only on the transition into DONE or on reset. During RUN they keep the previous result; the result is assembled in an internal register and copied on the RUN→DONE edge.
- Start while Busy or Done: ignored. A, B, Sub and Cin changes during RUN have no effect.
- Width rules:
  - Add mode: {Cout, Sum} = A + B + Cin exactly.
  - Sub mode: Sum = (A - B) mod 2^WIDTH.
  - Counter width is $clog2(WIDTH).
- Reset mid-operation: the operation is aborted silently and no Done is issued.

Decomposition:
- Shared package serial_adder_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a WIDTH_MAX=64 legality constant.
- One sub-module: the existing fullAdder cell (A, B, Cin → Sum, Cout), instantiated once for the per-bit sum/carry.
- FSM, counter, shift registers and output registers live in serial_adder.

Test Plan:
- WIDTH=8, Start with A=0x5A, B=0x3C, Sub=0, Cin=0 → Done exactly 9 cycles after the Start edge; Sum=0x96, Cout=0, Ovf=1.
- A=0xFF, B=0x01, Sub=0, Cin=1 → Sum=0x01, Cout=1, Ovf=0.
- Sub=1, A=0x10, B=0x20, Cin=1 (ignored) → Sum=0xF0, Cout=0, Ovf=0. Then Sub=1, A=0x80, B=0x01 → Sum=0x7F, Cout=1, Ovf=1.
- Start 0x01+0x01, then pulse Start with A=0xFF, B=0xFF during RUN cycle 3 and again during DONE → both ignored; Sum=0x02, Cout=0; Ready=1 in cycle 10.
- Start 0x5A+0x3C, assert rst in RUN cycle 4 → next cycle Sum=0x00, Cout=0, Ovf=0, Done=0, Busy=0, Ready=1. A following 0x03+0x04 gives Sum=0x07.
- Start held high continuously with changing operands → accepted at cycles 0, 10, 20 only; each Done matches the operands present at its accept edge. Repeat one case with WIDTH=2 and WIDTH=32.
